// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the accumulator computer run controller:
// sequencer states, default widths and instruction field positions.
package cpu_ctrl_pkg;

    localparam int DEF_ADDR_W  = 4;
    localparam int DEF_INSTR_W = 9;
    localparam int DEF_CNT_W   = 16;

    // Instruction layout seen by the datapath decoder: opcode on top,
    // operand/address field below it.
    localparam int OPC_HI = 8;
    localparam int OPC_LO = 5;
    localparam int ARG_HI = 4;
    localparam int ARG_LO = 0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2,
        ST_HALT  = 2'd3
    } state_t;

endpackage

// File: rtl/cpu_run_ctrl.sv
// Run/step/breakpoint sequencer: owns pc and ir, issues one exec_en
// per instruction and counts retired instructions (saturating).
module cpu_run_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int INSTR_W = DEF_INSTR_W,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               step,
    input  logic               halt_req,
    input  logic               bp_en,
    input  logic [ADDR_W-1:0]  bp_addr,
    input  logic [INSTR_W-1:0] im_data,
    output logic [ADDR_W-1:0]  pc,
    output logic [INSTR_W-1:0] ir,
    output logic               exec_en,
    output logic               busy,
    output logic               halted,
    output logic               bp_hit,
    output logic [CNT_W-1:0]   retired
);

    state_t state;
    state_t state_nx;
    logic   run_mode;
    logic   bp_skip;
    logic   bp_match;
    logic   go;

    // A fresh resume skips the breakpoint once so the stopped
    // instruction itself can execute.
    assign bp_match = bp_en && (pc == bp_addr) && !bp_skip;
    assign go       = !halt_req && (step || start);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state decode; halt_req outranks step, step outranks start.
    always_comb begin
        state_nx = state;
        unique case (state)
            ST_IDLE, ST_HALT: begin
                if (go) state_nx = ST_FETCH;
            end
            ST_FETCH: begin
                if (halt_req)      state_nx = ST_HALT;
                else if (bp_match) state_nx = ST_HALT;
                else               state_nx = ST_EXEC;
            end
            ST_EXEC: begin
                if (halt_req || !run_mode) state_nx = ST_HALT;
                else                       state_nx = ST_FETCH;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // Status outputs decode straight from the state register.
    always_comb begin
        exec_en = (state == ST_EXEC);
        busy    = (state == ST_FETCH) || (state == ST_EXEC);
        halted  = (state == ST_HALT);
    end

    // Sequencer datapath: pc, ir, mode flags, breakpoint status, counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc       <= '0;
            ir       <= '0;
            run_mode <= 1'b0;
            bp_skip  <= 1'b0;
            bp_hit   <= 1'b0;
            retired  <= '0;
        end else begin
            unique case (state)
                ST_IDLE, ST_HALT: begin
                    if (go) begin
                        run_mode <= !step;
                        bp_skip  <= 1'b1;
                        bp_hit   <= 1'b0;
                    end
                end
                ST_FETCH: begin
                    if (!halt_req) begin
                        if (bp_match) begin
                            bp_hit <= 1'b1;
                        end else begin
                            ir      <= im_data;
                            bp_skip <= 1'b0;
                        end
                    end
                end
                ST_EXEC: begin
                    pc <= pc + 1'b1;
                    if (retired != {CNT_W{1'b1}}) begin
                        retired <= retired + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Self-checking bench for cpu_run_ctrl: scoreboard of expected
// execution addresses, checked against pc/ir at every exec_en.
module tb_cpu_run_ctrl;

    localparam int AW = 4;
    localparam int IW = 9;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          step = 1'b0;
    logic          halt_req = 1'b0;
    logic          bp_en = 1'b0;
    logic [AW-1:0] bp_addr = '0;
    logic [IW-1:0] im_data;
    logic [AW-1:0] pc;
    logic [IW-1:0] ir;
    logic          exec_en, busy, halted, bp_hit;
    logic [CW-1:0] retired;

    // Second instance with a 3-bit counter to reach saturation quickly.
    logic [IW-1:0] im_data2;
    logic [AW-1:0] pc2;
    logic [IW-1:0] ir2;
    logic          exec_en2, busy2, halted2, bp_hit2;
    logic [2:0]    retired2;

    logic [IW-1:0] mem [16];
    int            exp_q [$];
    int            total = 0;
    int            bad = 0;
    int            n_ret = 0;

    always #5 clk = ~clk;

    assign im_data  = mem[pc];
    assign im_data2 = mem[pc2];

    cpu_run_ctrl #(.ADDR_W(AW), .INSTR_W(IW), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .step(step),
        .halt_req(halt_req), .bp_en(bp_en), .bp_addr(bp_addr),
        .im_data(im_data), .pc(pc), .ir(ir), .exec_en(exec_en),
        .busy(busy), .halted(halted), .bp_hit(bp_hit),
        .retired(retired)
    );

    cpu_run_ctrl #(.ADDR_W(AW), .INSTR_W(IW), .CNT_W(3)) dut_sat (
        .clk(clk), .rst_n(rst_n), .start(start), .step(step),
        .halt_req(halt_req), .bp_en(bp_en), .bp_addr(bp_addr),
        .im_data(im_data2), .pc(pc2), .ir(ir2), .exec_en(exec_en2),
        .busy(busy2), .halted(halted2), .bp_hit(bp_hit2),
        .retired(retired2)
    );

    // Scoreboard: every exec_en pops the expected address.
    always @(negedge clk) begin
        if (rst_n && exec_en) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL exec_unexpected: pc=%0d ir=%h, none expected",
                         pc, ir);
            end else begin
                int e;
                e = exp_q.pop_front();
                if (pc !== e[AW-1:0] || ir !== mem[e]) begin
                    bad++;
                    $display("FAIL exec: pc=%0d ir=%h, want pc=%0d ir=%h",
                             pc, ir, e, mem[e]);
                end
            end
            n_ret++;
        end
    end

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic pulse_step();
        @(negedge clk) step = 1'b1;
        @(negedge clk) step = 1'b0;
    endtask

    task automatic wait_halted(input int budget, input string nm);
        int i;
        i = 0;
        while (!halted && i < budget) begin
            @(negedge clk);
            i++;
        end
        total++;
        if (!halted) begin
            bad++;
            $display("FAIL %s_timeout: halted=%b after %0d cycles, want 1",
                     nm, halted, budget);
        end
    endtask

    task automatic do_reset();
        @(negedge clk) rst_n = 1'b0;
        exp_q.delete();
        n_ret = 0;
        @(negedge clk) rst_n = 1'b1;
    endtask

    task automatic test_reset();
        int i;
        @(negedge clk);
        total++;
        if ({pc, ir, exec_en, busy, halted, bp_hit, retired} !== '0) begin
            bad++;
            $display("FAIL reset_init: pc=%0d ir=%h ex=%b bs=%b hl=%b bp=%b rt=%0d, want 0",
                     pc, ir, exec_en, busy, halted, bp_hit, retired);
        end
        exp_q.push_back(0);
        exp_q.push_back(1);
        pulse_start();
        i = 0;
        while (!(exec_en && pc == 1) && i < 10) begin
            @(negedge clk);
            i++;
        end
        total++;
        if (!(exec_en && pc == 1)) begin
            bad++;
            $display("FAIL reset_reach_exec: pc=%0d exec_en=%b, want pc=1 exec_en=1",
                     pc, exec_en);
        end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({pc, ir, exec_en, busy, halted, bp_hit, retired} !== '0) begin
            bad++;
            $display("FAIL reset_async: pc=%0d ir=%h ex=%b bs=%b hl=%b bp=%b rt=%0d, want 0",
                     pc, ir, exec_en, busy, halted, bp_hit, retired);
        end
        exp_q.delete();
        n_ret = 0;
        @(negedge clk) rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            total++;
            if (exec_en !== 1'b0 || busy !== 1'b0 || halted !== 1'b0) begin
                bad++;
                $display("FAIL reset_idle: ex=%b busy=%b halted=%b, want 0 0 0",
                         exec_en, busy, halted);
            end
        end
    endtask

    task automatic test_free_run();
        bp_en = 1'b0;
        for (int a = 0; a < 4; a++) exp_q.push_back(a);
        pulse_start();
        for (int k = 1; k <= 9; k++) begin
            if (k > 1) @(negedge clk);
            total++;
            if (pc !== AW'((k - 1) / 2) || exec_en !== (k % 2 == 0)) begin
                bad++;
                $display("FAIL run_k%0d: pc=%0d ex=%b, want pc=%0d ex=%b",
                         k, pc, exec_en, (k - 1) / 2, (k % 2 == 0));
            end
        end
        total++;
        if (retired !== 16'd4 || retired2 !== 3'd4) begin
            bad++;
            $display("FAIL run_retired: got %0d/%0d, want 4/4",
                     retired, retired2);
        end
        halt_req = 1'b1;
        @(negedge clk) halt_req = 1'b0;
        total++;
        if (halted !== 1'b1 || pc !== 4'd4 || retired !== 16'd4) begin
            bad++;
            $display("FAIL halt_fetch: halted=%b pc=%0d rt=%0d, want 1 4 4",
                     halted, pc, retired);
        end
    endtask

    task automatic test_breakpoint();
        do_reset();
        bp_en = 1'b1;
        bp_addr = 4'd4;
        for (int a = 0; a < 4; a++) exp_q.push_back(a);
        pulse_start();
        wait_halted(40, "bp1");
        total++;
        if (pc !== 4'd4 || bp_hit !== 1'b1 || retired !== 16'd4) begin
            bad++;
            $display("FAIL bp_stop: pc=%0d bp_hit=%b rt=%0d, want 4 1 4",
                     pc, bp_hit, retired);
        end
        for (int a = 0; a < 16; a++) exp_q.push_back((a + 4) % 16);
        pulse_start();
        total++;
        if (bp_hit !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL bp_resume: bp_hit=%b busy=%b, want 0 1",
                     bp_hit, busy);
        end
        @(negedge clk);
        wait_halted(60, "bp2");
        total++;
        if (pc !== 4'd4 || bp_hit !== 1'b1 || retired !== 16'd20 ||
            exp_q.size() != 0) begin
            bad++;
            $display("FAIL bp_rearm: pc=%0d bp_hit=%b rt=%0d left=%0d, want 4 1 20 0",
                     pc, bp_hit, retired, exp_q.size());
        end
    endtask

    task automatic test_step();
        bp_addr = 4'd2;
        for (int a = 4; a < 18; a++) exp_q.push_back(a % 16);
        pulse_start();
        wait_halted(60, "to_pc2");
        total++;
        if (pc !== 4'd2 || retired !== 16'd34) begin
            bad++;
            $display("FAIL step_setup: pc=%0d rt=%0d, want 2 34", pc, retired);
        end
        bp_en = 1'b0;
        exp_q.push_back(2);
        pulse_step();
        total++;
        if (busy !== 1'b1 || exec_en !== 1'b0) begin
            bad++;
            $display("FAIL step_fetch: busy=%b ex=%b, want 1 0", busy, exec_en);
        end
        @(negedge clk);
        total++;
        if (exec_en !== 1'b1 || ir !== mem[2]) begin
            bad++;
            $display("FAIL step_exec: ex=%b ir=%h, want 1 %h",
                     exec_en, ir, mem[2]);
        end
        @(negedge clk);
        total++;
        if (halted !== 1'b1 || pc !== 4'd3 || retired !== 16'd35 ||
            bp_hit !== 1'b0) begin
            bad++;
            $display("FAIL step_done: hl=%b pc=%0d rt=%0d bp=%b, want 1 3 35 0",
                     halted, pc, retired, bp_hit);
        end
    endtask

    task automatic test_edge();
        @(negedge clk);
        halt_req = 1'b1;
        start = 1'b1;
        @(negedge clk);
        halt_req = 1'b0;
        start = 1'b0;
        @(negedge clk);
        total++;
        if (halted !== 1'b1 || busy !== 1'b0 || pc !== 4'd3) begin
            bad++;
            $display("FAIL halt_vs_start: hl=%b busy=%b pc=%0d, want 1 0 3",
                     halted, busy, pc);
        end
        for (int a = 3; a < 7; a++) exp_q.push_back(a);
        pulse_start();
        for (int k = 2; k <= 8; k++) @(negedge clk);
        total++;
        if (exec_en !== 1'b1 || pc !== 4'd6) begin
            bad++;
            $display("FAIL exec_at6: ex=%b pc=%0d, want 1 6", exec_en, pc);
        end
        halt_req = 1'b1;
        @(negedge clk) halt_req = 1'b0;
        total++;
        if (halted !== 1'b1 || pc !== 4'd7 || retired !== 16'd39 ||
            retired !== CW'(n_ret)) begin
            bad++;
            $display("FAIL halt_exec: hl=%b pc=%0d rt=%0d model=%0d, want 1 7 39",
                     halted, pc, retired, n_ret);
        end
    endtask

    task automatic test_saturation();
        total++;
        if (retired2 !== 3'd7 || pc2 !== pc) begin
            bad++;
            $display("FAIL saturate: retired=%0d pc=%0d, want 7 pc=%0d",
                     retired2, pc2, pc);
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = IW'($urandom_range(1, 511));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        test_reset();
        test_free_run();
        test_breakpoint();
        test_step();
        test_edge();
        test_saturation();
        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
